exe_hazard_ctrl: RTL and testbench



---
 rtl/exe_hazard_ctrl_pkg.sv | 17 +
 rtl/exe_hazard_ctrl_fwd_select.sv | 28 ++
 rtl/exe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared definitions for the EXE-stage hazard/forwarding controller:
// forwarding select encodings, sequencer state encoding and default widths.
package exe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF    = 5;
  localparam int FORWARDING_LENGTH = 2;

  localparam logic [FORWARDING_LENGTH-1:0] FWD_SRC_REG = 2'd0;
  localparam logic [FORWARDING_LENGTH-1:0] FWD_SRC_MEM = 2'd1;
  localparam logic [FORWARDING_LENGTH-1:0] FWD_SRC_WB  = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MC_BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/exe_hazard_ctrl_fwd_select.sv
// Single-source forwarding select: picks register file, MEM ALU result or WB
// result for one EXE operand. MEM is younger than WB, so it wins on a tie.
module exe_hazard_ctrl_fwd_select
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                         forward_en,
  input  logic [REG_ADDR_W-1:0]        src,
  input  logic [REG_ADDR_W-1:0]        mem_dest,
  input  logic                         mem_wb_en,
  input  logic [REG_ADDR_W-1:0]        wb_dest,
  input  logic                         wb_wb_en,
  output logic [FORWARDING_LENGTH-1:0] sel
);

  always_comb begin
    sel = FWD_SRC_REG;
    if (forward_en && (src != '0)) begin
      if (mem_wb_en && (src == mem_dest)) begin
        sel = FWD_SRC_MEM;
      end else if (wb_wb_en && (src == wb_dest)) begin
        sel = FWD_SRC_WB;
      end
    end
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage pipeline control: operand/store forwarding selects, ID read-after-write
// hazard stall, and a freeze sequencer for fixed-latency multi-cycle EXE commands.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no command in flight; a multi-cycle command freezes on entry
//   ST_MC_BUSY | command in flight; cnt counts remaining freeze cycles down
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         forward_en,
  input  logic [REG_ADDR_W-1:0]        exe_src1,
  input  logic [REG_ADDR_W-1:0]        exe_src2,
  input  logic [REG_ADDR_W-1:0]        exe_st_src,
  input  logic                         exe_multi,
  input  logic [REG_ADDR_W-1:0]        exe_dest,
  input  logic                         exe_wb_en,
  input  logic                         exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0]        mem_dest,
  input  logic [REG_ADDR_W-1:0]        wb_dest,
  input  logic                         mem_wb_en,
  input  logic                         wb_wb_en,
  input  logic [REG_ADDR_W-1:0]        id_src1,
  input  logic [REG_ADDR_W-1:0]        id_src2,
  input  logic                         id_two_src,
  input  logic                         flush,
  output logic [FORWARDING_LENGTH-1:0] value1_select,
  output logic [FORWARDING_LENGTH-1:0] value2_select,
  output logic [FORWARDING_LENGTH-1:0] ST_val_sel,
  output logic                         hazard_stall,
  output logic                         freeze_all,
  output logic                         mc_done
);

  logic [FORWARDING_LENGTH-1:0] sel1;
  logic [FORWARDING_LENGTH-1:0] sel2;
  logic [FORWARDING_LENGTH-1:0] sel_st;

  exe_hazard_ctrl_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_src1 (
    .forward_en (forward_en),
    .src        (exe_src1),
    .mem_dest   (mem_dest),
    .mem_wb_en  (mem_wb_en),
    .wb_dest    (wb_dest),
    .wb_wb_en   (wb_wb_en),
    .sel        (sel1)
  );

  exe_hazard_ctrl_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_src2 (
    .forward_en (forward_en),
    .src        (exe_src2),
    .mem_dest   (mem_dest),
    .mem_wb_en  (mem_wb_en),
    .wb_dest    (wb_dest),
    .wb_wb_en   (wb_wb_en),
    .sel        (sel2)
  );

  exe_hazard_ctrl_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_st (
    .forward_en (forward_en),
    .src        (exe_st_src),
    .mem_dest   (mem_dest),
    .mem_wb_en  (mem_wb_en),
    .wb_dest    (wb_dest),
    .wb_wb_en   (wb_wb_en),
    .sel        (sel_st)
  );

  // Outputs are forced low for the whole reset window, not just after the edge.
  assign value1_select = rst ? FWD_SRC_REG : sel1;
  assign value2_select = rst ? FWD_SRC_REG : sel2;
  assign ST_val_sel    = rst ? FWD_SRC_REG : sel_st;

  logic src1_live;
  logic src2_live;
  logic exe_match;
  logic mem_match;
  logic hazard;

  always_comb begin
    src1_live = (id_src1 != '0);
    src2_live = id_two_src && (id_src2 != '0);
    exe_match = exe_wb_en && ((src1_live && (id_src1 == exe_dest)) ||
                              (src2_live && (id_src2 == exe_dest)));
    mem_match = mem_wb_en && ((src1_live && (id_src1 == mem_dest)) ||
                              (src2_live && (id_src2 == mem_dest)));
    // With forwarding only a load in EXE is unresolvable; without it any
    // in-flight producer in EXE or MEM blocks the ID instruction.
    if (forward_en) begin
      hazard = exe_match && exe_mem_r_en;
    end else begin
      hazard = exe_match || mem_match;
    end
  end

  mc_state_t        state;
  mc_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             freeze_c;
  logic             done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    freeze_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exe_multi && !flush) begin
          freeze_c = 1'b1;
          cnt_nx   = CNT_W'(MC_LATENCY - 2);
          state_nx = ST_MC_BUSY;
        end
      end
      ST_MC_BUSY: begin
        if (flush) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (cnt != '0) begin
          freeze_c = 1'b1;
          cnt_nx   = cnt - CNT_W'(1);
        end else begin
          done_c   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign freeze_all   = freeze_c && !rst;
  assign mc_done      = done_c && !rst;
  assign hazard_stall = hazard && !freeze_c && !flush && !rst;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Self-checking bench for exe_hazard_ctrl: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exe_hazard_ctrl;

  localparam int AW = 5;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          forward_en;
  logic [AW-1:0] exe_src1, exe_src2, exe_st_src, exe_dest;
  logic          exe_multi, exe_wb_en, exe_mem_r_en;
  logic [AW-1:0] mem_dest, wb_dest, id_src1, id_src2;
  logic          mem_wb_en, wb_wb_en, id_two_src, flush;
  logic [1:0]    value1_select, value2_select, ST_val_sel;
  logic          hazard_stall, freeze_all, mc_done;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: whether a command is in flight and how many cycles it has
  // already spent in EXE (entry cycle is age 0).
  bit m_busy = 0;
  int m_age  = 0;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.REG_ADDR_W(AW), .MC_LATENCY(L), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .forward_en    (forward_en),
    .exe_src1      (exe_src1),
    .exe_src2      (exe_src2),
    .exe_st_src    (exe_st_src),
    .exe_multi     (exe_multi),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_r_en  (exe_mem_r_en),
    .mem_dest      (mem_dest),
    .wb_dest       (wb_dest),
    .mem_wb_en     (mem_wb_en),
    .wb_wb_en      (wb_wb_en),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_two_src    (id_two_src),
    .flush         (flush),
    .value1_select (value1_select),
    .value2_select (value2_select),
    .ST_val_sel    (ST_val_sel),
    .hazard_stall  (hazard_stall),
    .freeze_all    (freeze_all),
    .mc_done       (mc_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_sel(input logic [AW-1:0] src);
    if (rst || !forward_en || src == 0) return 0;
    if (mem_wb_en && src == mem_dest) return 1;
    if (wb_wb_en && src == wb_dest) return 2;
    return 0;
  endfunction

  function automatic bit m_hazard();
    logic [AW-1:0] srcs[$];
    bit e = 0, m = 0;
    srcs.push_back(id_src1);
    if (id_two_src) srcs.push_back(id_src2);
    foreach (srcs[i]) begin
      if (srcs[i] != 0 && exe_wb_en && srcs[i] == exe_dest) e = 1;
      if (srcs[i] != 0 && mem_wb_en && srcs[i] == mem_dest) m = 1;
    end
    return forward_en ? (e && exe_mem_r_en) : (e || m);
  endfunction

  function automatic bit m_freeze();
    if (rst) return 0;
    if (!m_busy) return exe_multi && !flush;
    return !flush && (m_age < L - 1);
  endfunction

  function automatic bit m_done();
    if (rst || !m_busy) return 0;
    return !flush && (m_age == L - 1);
  endfunction

  task automatic compare_all();
    bit fz;
    fz = m_freeze();
    chk("value1_select", value1_select, m_sel(exe_src1));
    chk("value2_select", value2_select, m_sel(exe_src2));
    chk("ST_val_sel",    ST_val_sel,    m_sel(exe_st_src));
    chk("freeze_all",    freeze_all,    fz);
    chk("mc_done",       mc_done,       m_done());
    chk("hazard_stall",  hazard_stall,  m_hazard() && !fz && !flush && !rst);
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (exe_multi && !flush) begin
        m_busy = 1;
        m_age  = 1;
      end
    end else if (flush || m_age >= L - 1) begin
      m_busy = 0;
      m_age  = 0;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic clear_inputs();
    forward_en = 0; exe_src1 = 0; exe_src2 = 0; exe_st_src = 0; exe_dest = 0;
    exe_multi = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; wb_dest = 0;
    mem_wb_en = 0; wb_wb_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    // Inputs that would otherwise forward and freeze; reset must mask them.
    forward_en = 1; exe_src1 = 3; mem_dest = 3; mem_wb_en = 1; exe_multi = 1;
    sample();
    chk("rst_value1", value1_select, 0);
    chk("rst_freeze", freeze_all, 0);
    advance();
    advance();
    rst = 0;
    clear_inputs();
    sample(); advance();

    // Forwarding priorities
    forward_en = 1; exe_src1 = 3; mem_dest = 3; mem_wb_en = 1; wb_dest = 3; wb_wb_en = 1;
    sample(); chk("fwd_mem_prio", value1_select, 1); advance();
    mem_wb_en = 0;
    sample(); chk("fwd_wb", value1_select, 2); advance();
    exe_src1 = 0;
    sample(); chk("fwd_r0", value1_select, 0); advance();
    clear_inputs();
    exe_st_src = 7; wb_dest = 7; wb_wb_en = 1; forward_en = 0;
    sample(); chk("st_fwd_off", ST_val_sel, 0); advance();
    forward_en = 1;
    sample(); chk("st_fwd_wb", ST_val_sel, 2); advance();

    // Load-use hazard
    clear_inputs();
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src2 = 5; id_two_src = 1;
    sample(); chk("loaduse_two_src", hazard_stall, 1); advance();
    id_two_src = 0;
    sample(); chk("loaduse_one_src", hazard_stall, 0); advance();
    id_two_src = 1; exe_mem_r_en = 0;
    sample(); chk("no_load_fwd", hazard_stall, 0); advance();

    // Multi-cycle command, concurrent hazard in the second cycle
    clear_inputs();
    exe_multi = 1;
    sample(); chk("mc_freeze_t0", freeze_all, 1); advance();
    exe_multi = 0;
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
    sample(); chk("mc_freeze_t1", freeze_all, 1); chk("mc_stall_masked", hazard_stall, 0); advance();
    clear_inputs();
    sample(); chk("mc_freeze_t2", freeze_all, 1); advance();
    sample(); chk("mc_freeze_t3", freeze_all, 0); chk("mc_done_t3", mc_done, 1); advance();
    sample(); chk("mc_idle_freeze", freeze_all, 0); chk("mc_idle_done", mc_done, 0); advance();

    // Back-to-back commands: no idle gap after mc_done
    exe_multi = 1;
    for (int i = 0; i < L; i++) begin
      sample(); chk("b2b_first", freeze_all, (i < L - 1) ? 1 : 0); advance();
    end
    sample(); chk("b2b_second_freeze", freeze_all, 1); advance();
    exe_multi = 0;
    repeat (L) begin sample(); advance(); end

    // Flush aborts a command
    exe_multi = 1;
    sample(); chk("fl_freeze_t0", freeze_all, 1); advance();
    exe_multi = 0; flush = 1;
    sample(); chk("fl_freeze_t1", freeze_all, 0); chk("fl_done_t1", mc_done, 0); advance();
    flush = 0;
    sample(); chk("fl_idle_freeze", freeze_all, 0); chk("fl_idle_done", mc_done, 0); advance();

    // Asynchronous reset mid-command
    exe_multi = 1;
    sample(); advance();
    exe_multi = 0; forward_en = 1; exe_src2 = 4; mem_dest = 4; mem_wb_en = 1;
    sample(); chk("ar_busy_freeze", freeze_all, 1);
    #2 rst = 1;
    #1;
    m_busy = 0; m_age = 0;
    chk("ar_freeze", freeze_all, 0);
    chk("ar_value2", value2_select, 0);
    chk("ar_done", mc_done, 0);
    advance();
    rst = 0;
    sample(); chk("ar_after_freeze", freeze_all, 0); chk("ar_after_value2", value2_select, 1); advance();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      forward_en   = ($urandom_range(0, 3) != 0);
      exe_src1     = AW'($urandom_range(0, 7));
      exe_src2     = AW'($urandom_range(0, 7));
      exe_st_src   = AW'($urandom_range(0, 7));
      exe_dest     = AW'($urandom_range(0, 7));
      mem_dest     = AW'($urandom_range(0, 7));
      wb_dest      = AW'($urandom_range(0, 7));
      id_src1      = AW'($urandom_range(0, 7));
      id_src2      = AW'($urandom_range(0, 7));
      exe_wb_en    = $urandom_range(0, 1);
      exe_mem_r_en = $urandom_range(0, 1);
      mem_wb_en    = $urandom_range(0, 1);
      wb_wb_en     = $urandom_range(0, 1);
      id_two_src   = $urandom_range(0, 1);
      exe_multi    = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 59) == 0);
      sample();
      advance();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
